// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the decode stage. Owns the PC and issues
// one word-aligned request at a time to a variable-latency instruction
// memory. The returned word and its PC are held in an output register with
// valid/stall handshaking toward decode. A redirect (taken branch/jump)
// reloads the PC, flushes the held instruction and marks any in-flight
// response for discard.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   stall_i        in   decode cannot accept; output register holds
//   redirect_i     in   load redirect_pc_i and flush
//   redirect_pc_i  in   redirect target (low two bits ignored)
//   imem_req_o     out  one-cycle request strobe
//   imem_addr_o    out  request address (current PC)
//   imem_rvalid_i  in   response valid, exactly one per request
//   imem_rdata_i   in   response instruction word
//   instruction_o  out  instruction to decode (NOP_INSTR when not valid)
//   pc_o           out  PC of instruction_o
//   valid_o        out  instruction_o/pc_o hold a live instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned                 DATA_WIDTH  = 32,
    parameter int unsigned                 INSTRUCTION = 32,
    parameter logic [DATA_WIDTH-1:0]       RESET_PC    = 32'h0000_0000,
    parameter logic [INSTRUCTION-1:0]      NOP_INSTR   = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [DATA_WIDTH-1:0]   redirect_pc_i,
    output logic                    imem_req_o,
    output logic [DATA_WIDTH-1:0]   imem_addr_o,
    input  logic                    imem_rvalid_i,
    input  logic [INSTRUCTION-1:0]  imem_rdata_i,
    output logic [INSTRUCTION-1:0]  instruction_o,
    output logic [DATA_WIDTH-1:0]   pc_o,
    output logic                    valid_o
);

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_RESET_ALIGNED = {RESET_PC[DATA_WIDTH-1:2], 2'b00};
    localparam logic [DATA_WIDTH-1:0] PC_STEP          = DATA_WIDTH'(4);

    // Registered state
    state_t                   r_state;
    logic [DATA_WIDTH-1:0]    r_pc;
    logic                     r_valid;
    logic [INSTRUCTION-1:0]   r_instr;
    logic [DATA_WIDTH-1:0]    r_pc_out;

    // Next-state values
    state_t                   w_state_nxt;
    logic [DATA_WIDTH-1:0]    w_pc_nxt;
    logic                     w_valid_nxt;
    logic [INSTRUCTION-1:0]   w_instr_nxt;
    logic [DATA_WIDTH-1:0]    w_pc_out_nxt;

    logic                     w_req;
    logic [DATA_WIDTH-1:0]    w_redirect_target;
    logic                     w_unused_redirect_lsbs;

    assign w_redirect_target      = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // A request may only go out when the output register will be free by
    // the time the response lands: either it is empty now or it is being
    // consumed at this edge.
    assign w_req = (r_state == ST_FETCH) && (!r_valid || !stall_i) && !redirect_i && !rst;

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign instruction_o = r_instr;
    assign pc_o          = r_pc_out;
    assign valid_o       = r_valid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= PC_RESET_ALIGNED;
            r_valid  <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_pc_out <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_valid  <= w_valid_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output-register logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;

        // Consumption by decode empties the register unless a capture
        // below overwrites it in the same cycle.
        if (r_valid && !stall_i) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
        end

        unique case (r_state)
            ST_FETCH: begin
                if (w_req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    w_instr_nxt  = imem_rdata_i;
                    w_pc_out_nxt = r_pc;
                    w_valid_nxt  = 1'b1;
                    w_pc_nxt     = r_pc + PC_STEP;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_WAIT_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Redirect overrides capture and stall. An outstanding request
        // cannot be cancelled at the memory, so WAIT turns into WAIT_DROP
        // to swallow the stale response unless it is arriving right now.
        if (redirect_i) begin
            w_pc_nxt    = w_redirect_target;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
            unique case (r_state)
                ST_FETCH:     w_state_nxt = ST_FETCH;
                ST_WAIT,
                ST_WAIT_DROP: w_state_nxt = imem_rvalid_i ? ST_FETCH : ST_WAIT_DROP;
                default:      w_state_nxt = ST_FETCH;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
        r_pc[1:0] == 2'b00);

    a_no_rvalid_when_idle: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (r_state != ST_FETCH));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;

    always #5 clk = ~clk;

    fetch_stage #(
        .DATA_WIDTH  (32),
        .INSTRUCTION (32),
        .RESET_PC    (32'h0000_0000),
        .NOP_INSTR   (32'h0000_0013)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] target;
        int unsigned lat;
        int unsigned delay;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vecs[5];

    // Memory model state
    bit          mem_busy;
    bit          mem_keep;
    logic [31:0] mem_addr;
    int unsigned mem_wait;
    int unsigned lat;
    logic [31:0] exp_pc;
    bit          seen_req;
    logic [31:0] seen_addr;
    int          cyc;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic tick();
        exp_t e;
        imem_rvalid_i = mem_busy && (mem_wait == 0);
        imem_rdata_i  = imem_rvalid_i ? img(mem_addr) : 32'hDEAD_BEEF;
        if (redirect_i && mem_busy) mem_keep = 1'b0;
        #1;
        seen_req  = imem_req_o;
        seen_addr = imem_addr_o;
        if (rst) check("req_in_reset", 32'(imem_req_o), 32'h0);
        if (seen_req) begin
            check("single_outstanding", 32'(mem_busy), 32'h0);
            check("req_addr", seen_addr, exp_pc);
        end
        if (valid_o && !stall_i && !redirect_i && !rst) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got pc_o %h with no expected entry", pc_o);
            end else begin
                e = sb.pop_front();
                check("sb_pc", pc_o, e.pc);
                check("sb_instr", instruction_o, e.ins);
            end
        end
        @(posedge clk);
        if (imem_rvalid_i) begin
            mem_busy = 1'b0;
            if (mem_keep) begin
                sb.push_back('{mem_addr, img(mem_addr)});
                exp_pc = mem_addr + 32'd4;
            end
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (seen_req) begin
            mem_busy = 1'b1;
            mem_keep = 1'b1;
            mem_addr = seen_addr;
            mem_wait = lat - 1;
        end
        if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
        if (rst) begin
            mem_busy = 1'b0;
            exp_pc   = 32'h0;
            sb.delete();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_req(input bit chk_idle, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (chk_idle) check({name, "_idle_valid"}, 32'(valid_o), 32'h0);
            got = seen_req;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_req_timeout: got no request expected one within 20 cycles", name);
        end
    endtask

    task automatic run_until_valid(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = valid_o;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_valid_timeout: got valid_o=0 expected 1 within 20 cycles", name);
        end
    endtask

    initial begin
        int  req_cyc[3];
        int  nreq;
        int  first_valid;
        bit  found;

        vecs[0] = '{32'h0000_0100, 3, 1, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0203, 1, 0, 32'h0000_0200, 32'h0000_0204};
        vecs[2] = '{32'h0000_1001, 4, 0, 32'h0000_1000, 32'h0000_1004};
        vecs[3] = '{32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h0000_07FF, 2, 1, 32'h0000_07FC, 32'h0000_0800};

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        mem_busy = 1'b0; mem_keep = 1'b0; mem_addr = '0; mem_wait = 0;
        lat = 1; exp_pc = 32'h0; cyc = 0;

        @(negedge clk);
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_instr", instruction_o, NOP);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        rst = 1'b0;

        // Streaming with 1-cycle memory, no stall, until pc_o=8 is held.
        nreq = 0; first_valid = -1; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (seen_req && nreq < 3) begin
                req_cyc[nreq] = cyc;
                nreq++;
            end
            if (valid_o && first_valid < 0) first_valid = cyc;
            if (valid_o && pc_o == 32'h8) found = 1'b1;
        end
        check("stream_reached_pc8", 32'(found), 32'h1);
        check("stream_nreq", 32'(nreq), 32'd3);
        check("req_gap_0_4", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
        check("req_gap_4_8", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
        check("first_latency", 32'(first_valid - req_cyc[0]), 32'd1);

        // Stall for 5 cycles while pc_o=8 is held.
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_noreq", 32'(seen_req), 32'h0);
            check("stall_valid", 32'(valid_o), 32'h1);
            check("stall_pc", pc_o, 32'h8);
            check("stall_instr", instruction_o, img(32'h8));
        end
        stall_i = 1'b0;
        tick();
        check("release_req", 32'(seen_req), 32'h1);
        check("release_addr", seen_addr, 32'hC);

        // Redirect vectors.
        foreach (vecs[k]) begin
            lat = vecs[k].lat;
            run_until_req(1'b0, "vec_pre");
            for (int d = 0; d < int'(vecs[k].delay); d++) tick();
            redirect_i    = 1'b1;
            redirect_pc_i = vecs[k].target;
            tick();
            redirect_i    = 1'b0;
            check("vec_flush_valid", 32'(valid_o), 32'h0);
            check("vec_flush_instr", instruction_o, NOP);
            run_until_req(1'b1, "vec");
            check("vec_addr", seen_addr, vecs[k].exp_addr);
            run_until_valid("vec_first");
            check("vec_pc_first", pc_o, vecs[k].exp_addr);
            check("vec_instr_first", instruction_o, img(vecs[k].exp_addr));
            run_until_valid("vec_second");
            check("vec_pc_second", pc_o, vecs[k].exp_next);
        end

        // Two redirects while waiting: the newest target wins.
        lat = 4;
        run_until_req(1'b0, "dbl_pre");
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        tick();
        redirect_pc_i = 32'h0000_0404;
        tick();
        redirect_i = 1'b0;
        run_until_req(1'b1, "dbl");
        check("dbl_addr", seen_addr, 32'h0000_0404);
        run_until_valid("dbl");
        check("dbl_pc", pc_o, 32'h0000_0404);

        // Reset in the middle of a wait.
        lat = 3;
        run_until_req(1'b0, "rstw_pre");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_valid", 32'(valid_o), 32'h0);
        check("rstw_instr", instruction_o, NOP);
        lat = 1;
        run_until_req(1'b1, "rstw");
        check("rstw_addr", seen_addr, 32'h0);
        run_until_valid("rstw");
        check("rstw_pc", pc_o, 32'h0);
        check("rstw_instr_val", instruction_o, img(32'h0));
        tick();
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
